// File: rtl/cpu_clock_controller.sv
// CPU clock controller: turns the divided slow_clk into single-clkin-cycle cpu_en
// pulses, with run / single-step / halt control and an executed-cycle counter.
module cpu_clock_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DB_W            = 5,
    parameter int CNT_W           = 16
) (
    input  logic             clkin,
    input  logic             clr_n,
    input  logic             slow_clk,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2,
        HALTED    = 2'd3
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Bit order in the synchroniser: {halt_req, step_btn, run_sw, slow_clk}
    logic [3:0]       r_sync0;
    logic [3:0]       r_sync1;
    logic             r_slowPrev;
    logic             r_btnHeld;
    logic             r_btnHeldPrev;
    logic [DB_W-1:0]  r_dbCnt;
    state_t           r_state;
    logic             r_cpuEn;
    logic [CNT_W-1:0] r_count;

    state_t           w_nextState;
    logic             w_nextCpuEn;
    logic             w_slowS;
    logic             w_runS;
    logic             w_btnS;
    logic             w_haltS;
    logic             w_tick;
    logic             w_stepPress;

    assign w_slowS     = r_sync1[0];
    assign w_runS      = r_sync1[1];
    assign w_btnS      = r_sync1[2];
    assign w_haltS     = r_sync1[3];
    assign w_tick      = w_slowS & ~r_slowPrev;
    assign w_stepPress = r_btnHeld & ~r_btnHeldPrev;

    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n) begin
            r_sync0    <= '0;
            r_sync1    <= '0;
            r_slowPrev <= 1'b0;
        end else begin
            r_sync0    <= {halt_req, step_btn, run_sw, slow_clk};
            r_sync1    <= r_sync0;
            r_slowPrev <= w_slowS;
        end
    end

    // A new button level is accepted only after DEBOUNCE_CYCLES differing samples in a row
    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n) begin
            r_btnHeld     <= 1'b0;
            r_btnHeldPrev <= 1'b0;
            r_dbCnt       <= '0;
        end else begin
            r_btnHeldPrev <= r_btnHeld;
            if (w_btnS == r_btnHeld) begin
                r_dbCnt <= '0;
            end else if (r_dbCnt == DB_LAST) begin
                r_btnHeld <= w_btnS;
                r_dbCnt   <= '0;
            end else if (r_dbCnt != {DB_W{1'b1}}) begin
                r_dbCnt <= r_dbCnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clkin or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_cpuEn <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_cpuEn <= w_nextCpuEn;
            if (r_cpuEn) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCpuEn = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_runS) begin
                    w_nextState = RUN;
                end else if (w_stepPress) begin
                    w_nextState = STEP_WAIT;
                end
            end
            RUN: begin
                if (w_haltS) begin
                    w_nextState = HALTED;
                end else if (!w_runS) begin
                    w_nextState = IDLE;
                end else if (w_tick) begin
                    w_nextCpuEn = 1'b1;
                end
            end
            STEP_WAIT: begin
                // Extra presses here are simply not looked at, so steps never queue
                if (w_haltS) begin
                    w_nextState = HALTED;
                end else if (w_tick) begin
                    w_nextCpuEn = 1'b1;
                    w_nextState = IDLE;
                end
            end
            HALTED: begin
                if (w_stepPress && !w_runS) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign cpu_en      = r_cpuEn;
    assign state       = r_state;
    assign running     = (r_state == RUN);
    assign halted      = (r_state == HALTED);
    assign cycle_count = r_count;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed testbench for cpu_clock_controller (DEBOUNCE_CYCLES=4, CNT_W=4).
module tb_cpu_clock_controller;

    logic       clkin;
    logic       clr_n;
    logic       slow_clk;
    logic       run_sw;
    logic       step_btn;
    logic       halt_req;
    logic       cpu_en;
    logic       running;
    logic       halted;
    logic [1:0] state;
    logic [3:0] cycle_count;

    int total;
    int bad;
    int expCount;

    cpu_clock_controller #(
        .DEBOUNCE_CYCLES(4),
        .DB_W(3),
        .CNT_W(4)
    ) dut (
        .clkin(clkin),
        .clr_n(clr_n),
        .slow_clk(slow_clk),
        .run_sw(run_sw),
        .step_btn(step_btn),
        .halt_req(halt_req),
        .cpu_en(cpu_en),
        .running(running),
        .halted(halted),
        .state(state),
        .cycle_count(cycle_count)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Outputs are sampled and inputs changed on the falling edge
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clkin);
    endtask

    // One full slow_clk period (11 high, 11 low); reports pulse count and first pulse position
    task automatic slow_period(output int pulses, output int firstPos);
        pulses   = 0;
        firstPos = -1;
        slow_clk = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clkin);
            if (cpu_en === 1'b1) begin
                if (firstPos < 0) firstPos = k;
                pulses++;
            end
            if (k == 11) slow_clk = 1'b0;
        end
    endtask

    task automatic press(input int holdCycles);
        step_btn = 1'b1;
        cycles(holdCycles);
        step_btn = 1'b0;
        cycles(10);
    endtask

    task automatic test_reset();
        clr_n = 1'b0; slow_clk = 1'b0; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
        cycles(3);
        total++;
        if ({cpu_en, running, halted, state, cycle_count} !== 9'b0) begin
            $display("[TB] FAIL reset_state got en=%b run=%b halt=%b st=%0d cnt=%0d want all 0",
                     cpu_en, running, halted, state, cycle_count);
            bad++;
        end
        clr_n = 1'b1;
        cycles(3);
        total++;
        if (state !== 2'd0) begin
            $display("[TB] FAIL idle_after_reset state=%0d want 0", state);
            bad++;
        end
        expCount = 0;
    endtask

    task automatic test_run();
        int p, pos;
        run_sw = 1'b1;
        cycles(4);
        total++;
        if (running !== 1'b1 || state !== 2'd1) begin
            $display("[TB] FAIL run_enter running=%b state=%0d want 1/1", running, state);
            bad++;
        end
        for (int n = 0; n < 5; n++) begin
            slow_period(p, pos);
            expCount++;
            total++;
            if (p !== 1 || pos !== 3) begin
                $display("[TB] FAIL run_pulse period=%0d pulses=%0d pos=%0d want 1 at 3", n, p, pos);
                bad++;
            end
        end
        total++;
        if (cycle_count !== 4'd5) begin
            $display("[TB] FAIL run_count cycle_count=%0d want 5", cycle_count);
            bad++;
        end
        run_sw = 1'b0;
        cycles(4);
        total++;
        if (state !== 2'd0) begin
            $display("[TB] FAIL run_exit state=%0d want 0", state);
            bad++;
        end
    endtask

    task automatic test_step();
        int p, pos, entries;
        logic [1:0] prevState;
        entries   = 0;
        prevState = state;
        for (int i = 0; i < 4; i++) begin
            step_btn = ~step_btn;
            @(negedge clkin);
            if (state === 2'd2 && prevState !== 2'd2) entries++;
            prevState = state;
        end
        step_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clkin);
            if (state === 2'd2 && prevState !== 2'd2) entries++;
            prevState = state;
        end
        total++;
        if (entries !== 1 || state !== 2'd2) begin
            $display("[TB] FAIL step_debounce entries=%0d state=%0d want 1/2", entries, state);
            bad++;
        end
        step_btn = 1'b0;
        cycles(10);
        press(10);
        total++;
        if (state !== 2'd2 || cpu_en !== 1'b0) begin
            $display("[TB] FAIL step_wait_hold state=%0d en=%b want 2/0", state, cpu_en);
            bad++;
        end
        slow_period(p, pos);
        expCount++;
        total++;
        if (p !== 1 || pos !== 3 || state !== 2'd0) begin
            $display("[TB] FAIL step_pulse pulses=%0d pos=%0d state=%0d want 1/3/0", p, pos, state);
            bad++;
        end
        total++;
        if (cycle_count !== 4'(expCount)) begin
            $display("[TB] FAIL step_count cycle_count=%0d want %0d", cycle_count, expCount);
            bad++;
        end
        slow_period(p, pos);
        total++;
        if (p !== 0) begin
            $display("[TB] FAIL step_no_queue pulses=%0d want 0", p);
            bad++;
        end
    endtask

    task automatic test_halt();
        int p, pos;
        run_sw = 1'b1;
        cycles(4);
        halt_req = 1'b1;
        slow_period(p, pos);
        total++;
        if (p !== 0 || state !== 2'd3 || halted !== 1'b1 || running !== 1'b0) begin
            $display("[TB] FAIL halt_enter pulses=%0d state=%0d halted=%b running=%b want 0/3/1/0",
                     p, state, halted, running);
            bad++;
        end
        halt_req = 1'b0;
        cycles(3);
        press(10);
        total++;
        if (state !== 2'd3) begin
            $display("[TB] FAIL halt_press_running state=%0d want 3", state);
            bad++;
        end
        run_sw = 1'b0;
        cycles(4);
        press(10);
        total++;
        if (state !== 2'd0 || halted !== 1'b0) begin
            $display("[TB] FAIL halt_ack state=%0d halted=%b want 0/0", state, halted);
            bad++;
        end
    endtask

    task automatic test_run_drop();
        int p, pos;
        run_sw = 1'b1;
        cycles(4);
        run_sw = 1'b0;
        slow_period(p, pos);
        total++;
        if (p !== 0 || state !== 2'd0) begin
            $display("[TB] FAIL run_drop pulses=%0d state=%0d want 0/0", p, state);
            bad++;
        end
    endtask

    task automatic test_mid_reset();
        run_sw = 1'b1;
        cycles(4);
        slow_clk = 1'b1;
        cycles(3);
        total++;
        if (cpu_en !== 1'b1) begin
            $display("[TB] FAIL mid_reset_setup cpu_en=%b want 1", cpu_en);
            bad++;
        end
        clr_n    = 1'b0;
        slow_clk = 1'b0;
        #1;
        total++;
        if (cpu_en !== 1'b0 || cycle_count !== 4'd0 || state !== 2'd0) begin
            $display("[TB] FAIL mid_reset_async en=%b cnt=%0d state=%0d want 0/0/0",
                     cpu_en, cycle_count, state);
            bad++;
        end
        @(negedge clkin);
        clr_n = 1'b1;
        @(negedge clkin);
        total++;
        if (state !== 2'd0 || cpu_en !== 1'b0) begin
            $display("[TB] FAIL mid_reset_release state=%0d en=%b want 0/0", state, cpu_en);
            bad++;
        end
        cycles(3);
        total++;
        if (running !== 1'b1) begin
            $display("[TB] FAIL mid_reset_resume running=%b want 1", running);
            bad++;
        end
        expCount = 0;
    endtask

    task automatic test_wrap();
        int p, pos;
        for (int n = 0; n < 17; n++) begin
            slow_period(p, pos);
            expCount = (expCount + 1) % 16;
            total++;
            if (p !== 1 || cycle_count !== 4'(expCount)) begin
                $display("[TB] FAIL wrap_count tick=%0d pulses=%0d cnt=%0d want 1/%0d",
                         n, p, cycle_count, expCount);
                bad++;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_run();
        test_step();
        test_halt();
        test_run_drop();
        test_mid_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
